// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared FSM states, CTRL/status bit positions and register map helpers for divider_mmio
package divider_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum int {
        CTRL_START  = 0,
        CTRL_SIGNED = 1,
        CTRL_ACK    = 2,
        CTRL_IE     = 3
    } ctrl_bit_e;

    typedef enum int {
        STAT_SIGNED = 2,
        STAT_IE     = 3,
        STAT_DONE   = 5,
        STAT_DIV0   = 6,
        STAT_BUSY   = 7
    } stat_bit_e;

    typedef enum int {
        BANK_NUMER = 0,
        BANK_DENOM = 1,
        BANK_QUOT  = 2,
        BANK_REM   = 3,
        BANK_CTRL  = 4
    } bank_e;

    function automatic int reg_off(input int nb, input bank_e bank);
        return int'(bank) * nb;
    endfunction

endpackage

// File: rtl/divider_core.sv
// rtl/divider_core.sv - unsigned restoring divider, one quotient bit per clock, results combinational on done
module divider_core
    import divider_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] numer,
    input  logic [WIDTH-1:0] denom,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remain
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo, rem, den;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] quo_step, rem_step;

    // quo starts as the numerator and shifts out its MSB into the partial remainder
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, den};
        quo_step = {quo[WIDTH-2:0], ~diff[WIDTH]};
        rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end

    always_comb begin
        state_next = state;
        busy       = (state == RUN);
        div_zero   = (den == '0);
        done       = 1'b0;
        if (state == IDLE) begin
            if (start) state_next = RUN;
        end else if (div_zero || count == '0) begin
            done       = 1'b1;
            state_next = IDLE;
        end
        quotient = div_zero ? '1 : quo_step;
        remain   = div_zero ? quo : rem_step;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            quo   <= '0;
            rem   <= '0;
            den   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                quo   <= numer;
                rem   <= '0;
                den   <= denom;
                count <= CW'(WIDTH - 1);
            end else if (state == RUN) begin
                quo   <= quo_step;
                rem   <= rem_step;
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_mmio.sv
// rtl/divider_mmio.sv - byte-wide memory-mapped divider peripheral; SIGNED_DIV_EN enables two's-complement mode
module divider_mmio
    import divider_pkg::*;
#(
    parameter  int WIDTH  = 16,
    localparam int NB     = WIDTH / 8,
    localparam int ADDR_W = $clog2(4 * NB + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              rwb,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        i_data,
    output logic [7:0]        o_data,
    output logic              o_irq
);
    logic [WIDTH-1:0] numer_r, denom_r, quot_r, rem_r;
    logic             done_r, div0_r, ie_r, signed_r;
    logic             wr, ctrl_wr, start_req, ack_req;
    logic             core_busy, core_done, core_div0;
    logic [WIDTH-1:0] core_numer, core_denom, core_quot, core_rem;
    logic [WIDTH-1:0] quot_wb, rem_wb;
    logic [7:0]       status;

    assign wr        = cs & ~rwb;
    assign ctrl_wr   = wr && (int'(addr) == reg_off(NB, BANK_CTRL));
    assign start_req = ctrl_wr && i_data[CTRL_START] && !core_busy;
    assign ack_req   = ctrl_wr && i_data[CTRL_ACK];
    assign o_irq     = done_r & ie_r;

`ifdef SIGNED_DIV_EN
    logic n_neg, d_neg, neg_q, neg_r;

    // The SIGNED bit carried by the START write itself selects the mode of that operation
    assign n_neg      = i_data[CTRL_SIGNED] & numer_r[WIDTH-1];
    assign d_neg      = i_data[CTRL_SIGNED] & denom_r[WIDTH-1];
    assign core_numer = n_neg ? -numer_r : numer_r;
    assign core_denom = d_neg ? -denom_r : denom_r;
    assign quot_wb    = (neg_q && !core_div0) ? -core_quot : core_quot;
    assign rem_wb     = neg_r ? -core_rem : core_rem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            signed_r <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            if (ctrl_wr) signed_r <= i_data[CTRL_SIGNED];
            if (start_req) begin
                neg_q <= n_neg ^ d_neg;
                neg_r <= n_neg;
            end
        end
    end
`else
    assign signed_r   = 1'b0;
    assign core_numer = numer_r;
    assign core_denom = denom_r;
    assign quot_wb    = core_quot;
    assign rem_wb     = core_rem;
`endif

    divider_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .start    (start_req),
        .numer    (core_numer),
        .denom    (core_denom),
        .busy     (core_busy),
        .done     (core_done),
        .div_zero (core_div0),
        .quotient (core_quot),
        .remain   (core_rem)
    );

    always_comb begin
        status              = '0;
        status[STAT_BUSY]   = core_busy;
        status[STAT_DIV0]   = div0_r;
        status[STAT_DONE]   = done_r;
        status[STAT_IE]     = ie_r;
        status[STAT_SIGNED] = signed_r;
    end

    always_comb begin
        o_data = '0;
        for (int b = 0; b < NB; b++) begin
            if (int'(addr) == reg_off(NB, BANK_NUMER) + b) o_data = numer_r[8*b +: 8];
            if (int'(addr) == reg_off(NB, BANK_DENOM) + b) o_data = denom_r[8*b +: 8];
            if (int'(addr) == reg_off(NB, BANK_QUOT)  + b) o_data = quot_r[8*b +: 8];
            if (int'(addr) == reg_off(NB, BANK_REM)   + b) o_data = rem_r[8*b +: 8];
        end
        if (int'(addr) == reg_off(NB, BANK_CTRL)) o_data = status;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            numer_r <= '0;
            denom_r <= '0;
            quot_r  <= '0;
            rem_r   <= '0;
            done_r  <= 1'b0;
            div0_r  <= 1'b0;
            ie_r    <= 1'b0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (wr && int'(addr) == reg_off(NB, BANK_NUMER) + b) numer_r[8*b +: 8] <= i_data;
                if (wr && int'(addr) == reg_off(NB, BANK_DENOM) + b) denom_r[8*b +: 8] <= i_data;
            end
            if (ctrl_wr) ie_r <= i_data[CTRL_IE];
            // START beats ACK; completion cannot coincide with START since the core is busy then
            if (start_req) begin
                done_r <= 1'b0;
                div0_r <= 1'b0;
            end else if (core_done) begin
                quot_r <= quot_wb;
                rem_r  <= rem_wb;
                done_r <= 1'b1;
                div0_r <= core_div0;
            end else if (ack_req) begin
                done_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divider_mmio.sv
// tb/tb_divider_mmio.sv - directed self-checking bench for divider_mmio at WIDTH=16
module tb_divider_mmio;
    localparam int WIDTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int A_NUMER = 0;
    localparam int A_DENOM = 2;
    localparam int A_QUOT  = 4;
    localparam int A_REM   = 6;
    localparam int A_CTRL  = 8;

    logic              clk    = 1'b0;
    logic              reset  = 1'b0;
    logic              cs     = 1'b0;
    logic              rwb    = 1'b1;
    logic [ADDR_W-1:0] addr   = '0;
    logic [7:0]        i_data = '0;
    logic [7:0]        o_data;
    logic              o_irq;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    logic [7:0]  v8;
    logic [15:0] v16;

    divider_mmio #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .cs     (cs),
        .rwb    (rwb),
        .addr   (addr),
        .i_data (i_data),
        .o_data (o_data),
        .o_irq  (o_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        @(negedge clk);
        cs     = 1'b1;
        rwb    = 1'b0;
        addr   = ADDR_W'(a);
        i_data = d;
        @(posedge clk);
        #1;
        cs     = 1'b0;
        rwb    = 1'b1;
    endtask

    task automatic wr16(input int a, input logic [15:0] d);
        wr(a, d[7:0]);
        wr(a + 1, d[15:8]);
    endtask

    task automatic rd(input int a, output logic [7:0] v);
        addr = ADDR_W'(a);
        rwb  = 1'b1;
        cs   = 1'b1;
        #1;
        v    = o_data;
        cs   = 1'b0;
    endtask

    task automatic rd16(input int a, output logic [15:0] v);
        logic [7:0] lo, hi;
        rd(a, lo);
        rd(a + 1, hi);
        v = {hi, lo};
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        wait_clks(3);
        rd16(A_QUOT, v16);  check("rst_quot", v16, 16'h0000);
        rd16(A_REM, v16);   check("rst_rem", v16, 16'h0000);
        rd16(A_NUMER, v16); check("rst_numer", v16, 16'h0000);
        rd(A_CTRL, v8);     check("rst_ctrl", v8, 8'h00);
        check("rst_irq", o_irq, 1'b0);
        reset = 1'b1;

        // 1000 / 7 unsigned
        wr16(A_NUMER, 16'd1000);
        wr16(A_DENOM, 16'd7);
        wr(A_CTRL, 8'h01);
        rd(A_CTRL, v8);     check("u_busy_first", v8, 8'h80);
        wait_clks(15);
        rd(A_CTRL, v8);     check("u_busy_last", v8, 8'h80);
        wait_clks(1);
        rd(A_CTRL, v8);     check("u_done", v8, 8'h20);
        rd16(A_QUOT, v16);  check("u_quot", v16, 16'h008E);
        rd16(A_REM, v16);   check("u_rem", v16, 16'h0006);
        check("u_irq_off", o_irq, 1'b0);
        wr(A_CTRL, 8'h04);
        rd(A_CTRL, v8);     check("ack_clears", v8, 8'h00);

        // divide by zero
        wr16(A_NUMER, 16'h1234);
        wr16(A_DENOM, 16'h0000);
        wr(A_CTRL, 8'h01);
        rd(A_CTRL, v8);     check("dz_busy", v8, 8'h80);
        wait_clks(1);
        rd(A_CTRL, v8);     check("dz_ctrl", v8, 8'h60);
        rd16(A_QUOT, v16);  check("dz_quot", v16, 16'hFFFF);
        rd16(A_REM, v16);   check("dz_rem", v16, 16'h1234);

        // 0xFFF9 / 2 with SIGNED requested
        wr(A_CTRL, 8'h02);
        rd(A_CTRL, v8);
`ifdef SIGNED_DIV_EN
        check("s_ctrl_set", v8, 8'h64);
`else
        check("s_ctrl_set", v8, 8'h60);
`endif
        wr16(A_NUMER, 16'hFFF9);
        wr16(A_DENOM, 16'h0002);
        wr(A_CTRL, 8'h03);
        wait_clks(16);
        rd(A_CTRL, v8);
`ifdef SIGNED_DIV_EN
        check("s_ctrl_done", v8, 8'h24);
        rd16(A_QUOT, v16);  check("s_quot", v16, 16'hFFFD);
        rd16(A_REM, v16);   check("s_rem", v16, 16'hFFFF);
`else
        check("s_ctrl_done", v8, 8'h20);
        rd16(A_QUOT, v16);  check("s_quot", v16, 16'h7FFC);
        rd16(A_REM, v16);   check("s_rem", v16, 16'h0001);
`endif
        wr(A_CTRL, 8'h04);
        rd(A_CTRL, v8);     check("s_ack", v8, 8'h00);

        // 100 / 3 with NUMER rewrite and second START mid-run
        wr16(A_NUMER, 16'd100);
        wr16(A_DENOM, 16'd3);
        wr(A_CTRL, 8'h01);
        wait_clks(4);
        wr(A_NUMER, 8'd50);
        wr(A_CTRL, 8'h01);
        wait_clks(9);
        rd(A_CTRL, v8);     check("mid_busy_last", v8, 8'h80);
        wait_clks(1);
        rd(A_CTRL, v8);     check("mid_done", v8, 8'h20);
        rd16(A_QUOT, v16);  check("mid_quot", v16, 16'd33);
        rd16(A_REM, v16);   check("mid_rem", v16, 16'd1);
        rd16(A_NUMER, v16); check("mid_shadow", v16, 16'd50);

        // interrupt behaviour
        wr(A_CTRL, 8'h0C);
        rd(A_CTRL, v8);     check("irq_ie_set", v8, 8'h08);
        check("irq_idle", o_irq, 1'b0);
        wr16(A_NUMER, 16'd1000);
        wr16(A_DENOM, 16'd7);
        wr(A_CTRL, 8'h09);
        wait_clks(16);
        check("irq_raised", o_irq, 1'b1);
        rd(A_CTRL, v8);     check("irq_ctrl", v8, 8'h28);
        wr(A_CTRL, 8'h0C);
        check("irq_ack", o_irq, 1'b0);
        wr(A_CTRL, 8'h09);
        wait_clks(16);
        check("irq_raised2", o_irq, 1'b1);
        wr(A_CTRL, 8'h09);
        check("irq_start_clr", o_irq, 1'b0);
        rd(A_CTRL, v8);     check("irq_restart", v8, 8'h88);

        // asynchronous reset during RUN
        wait_clks(4);
        #2;
        reset = 1'b0;
        #1;
        rd(A_CTRL, v8);     check("ar_ctrl", v8, 8'h00);
        rd16(A_QUOT, v16);  check("ar_quot", v16, 16'h0000);
        rd16(A_REM, v16);   check("ar_rem", v16, 16'h0000);
        check("ar_irq", o_irq, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        wr16(A_NUMER, 16'd1000);
        wr16(A_DENOM, 16'd7);
        wr(A_CTRL, 8'h01);
        wait_clks(16);
        rd(A_CTRL, v8);     check("ar_after_ctrl", v8, 8'h20);
        rd16(A_QUOT, v16);  check("ar_after_quot", v16, 16'h008E);
        rd16(A_REM, v16);   check("ar_after_rem", v16, 16'h0006);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
